// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between instruction fetch (IF, read-only)
//   and the data stage (MEM, load/store). A two-state FSM (IDLE/ACCESS)
//   grants one requester, holds the memory request until mem_ready or a
//   timeout, and returns the response to the recorded owner.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   if_req/if_addr             fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata  one-cycle grant, one-cycle response + data
//   dm_req/dm_we/dm_addr/dm_wdata  data request (we=1 store), held until dm_gnt
//   dm_gnt/dm_rvalid/dm_rdata  one-cycle grant, one-cycle response (0 on store)
//   mem_req/mem_we/mem_addr/mem_wdata  memory request, held until mem_ready
//   mem_ready/mem_rdata        one-cycle completion strobe + read data
//   stall_if/stall_mem         combinational stall requests to hazard logic
//   err                        one-cycle pulse on timeout abort
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MAX_STREAK = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                owner_dm_q, owner_dm_d;
  logic [3:0]          streak_q, streak_d;
  logic [7:0]          tcnt_q, tcnt_d;
  logic                if_gnt_q, if_gnt_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                dm_gnt_q, dm_gnt_d;
  logic                dm_rvalid_q, dm_rvalid_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                err_q, err_d;

  logic                if_wins;
  logic                deliver;
  logic [DATA_W-1:0]   resp_data;

  // MEM has priority unless IF has already watched MAX_STREAK MEM grants.
  assign if_wins = if_req & (~dm_req | (streak_q == STREAK_MAX));

  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    err_d       = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    deliver     = 1'b0;
    resp_data   = '0;

    unique case (state_q)
      IDLE: begin
        mem_req_d = 1'b0;
        if (if_req | dm_req) begin
          state_d   = ACCESS;
          mem_req_d = 1'b1;
          tcnt_d    = '0;
          if (if_wins) begin
            owner_dm_d  = 1'b0;
            if_gnt_d    = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end else begin
            owner_dm_d  = 1'b1;
            dm_gnt_d    = 1'b1;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr;
            mem_wdata_d = dm_wdata;
            if (!if_req) begin
              streak_d = '0;
            end else if (streak_q != STREAK_MAX) begin
              streak_d = streak_q + 4'd1;
            end
          end
        end
      end
      ACCESS: begin
        if (mem_ready) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          deliver   = 1'b1;
          resp_data = (owner_dm_q & mem_we_q) ? '0 : mem_rdata;
        end else if (tcnt_q == TO_LAST) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          deliver   = 1'b1;
          err_d     = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
    endcase

    if (deliver) begin
      if (owner_dm_q) begin
        dm_rvalid_d = 1'b1;
        dm_rdata_d  = resp_data;
      end else begin
        if_rvalid_d = 1'b1;
        if_rdata_d  = resp_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_dm_q  <= 1'b0;
      streak_q    <= '0;
      tcnt_q      <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_gnt_q    <= 1'b0;
      dm_rvalid_q <= 1'b0;
      dm_rdata_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_gnt_q    <= dm_gnt_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_rdata_q  <= dm_rdata_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign dm_gnt    = dm_gnt_q;
  assign dm_rvalid = dm_rvalid_q;
  assign dm_rdata  = dm_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

  // Gated by rst_n so stalls read 0 while reset is held.
  assign stall_if  = rst_n & if_req & ~if_rvalid_q;
  assign stall_mem = rst_n & dm_req & ~dm_rvalid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MAXS = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          stall_if, stall_mem, err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_STREAK(MAXS), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory contents: phys is what the memory really holds (written through the
  // DUT's mem_* outputs); img is what the reference expects it to hold.
  logic [31:0] phys [256];
  logic [31:0] img  [256];

  // Memory responder: mode 0 random latency (sometimes never), 1 fixed, 2 never.
  int mem_mode = 0;
  int fixed_delay = 1;
  int noise_pct = 0;
  int acc_cnt = 0;
  int target = 1;
  always @(negedge clk) begin
    if (mem_req) begin
      acc_cnt++;
      if (target != 0 && acc_cnt == target) begin
        mem_ready = 1'b1;
        mem_rdata = phys[mem_addr[9:2]];
        if (mem_we) phys[mem_addr[9:2]] = mem_wdata;
      end else begin
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      acc_cnt = 0;
      case (mem_mode)
        1: target = fixed_delay;
        2: target = 0;
        default: target = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4));
      endcase
      mem_ready = (int'($urandom_range(0, 99)) < noise_pct);
      mem_rdata = $urandom;
    end
  end

  // Reference model: one outstanding transaction, judged at each clock edge.
  typedef struct {
    logic        is_dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  bit          busy;
  txn_t        cur;
  int          age;
  int          mem_wins_while_if_waits;
  logic        e_if_gnt, e_dm_gnt, e_if_rv, e_dm_rv, e_err;
  logic [31:0] e_if_rdata, e_dm_rdata;
  logic [31:0] m_data;
  bit          m_take_if;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy = 0; age = 0; mem_wins_while_if_waits = 0;
      e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0; e_err = 0;
      e_if_rdata = 0; e_dm_rdata = 0;
    end else begin
      e_if_gnt = 0; e_dm_gnt = 0; e_if_rv = 0; e_dm_rv = 0; e_err = 0;
      if (!busy) begin
        if (if_req || dm_req) begin
          m_take_if = if_req && (!dm_req || mem_wins_while_if_waits >= MAXS);
          if (m_take_if) begin
            cur = '{1'b0, 1'b0, if_addr, 32'd0};
            e_if_gnt = 1;
            mem_wins_while_if_waits = 0;
          end else begin
            cur = '{1'b1, dm_we, dm_addr, dm_wdata};
            e_dm_gnt = 1;
            mem_wins_while_if_waits = if_req ? mem_wins_while_if_waits + 1 : 0;
          end
          busy = 1;
          age = 0;
        end
      end else begin
        age++;
        if (mem_ready || age == TO) begin
          m_data = 0;
          if (mem_ready) begin
            m_data = img[cur.addr[9:2]];
            if (cur.we) begin
              img[cur.addr[9:2]] = cur.wdata;
              m_data = 0;
            end
          end else begin
            e_err = 1;
          end
          if (cur.is_dm) begin e_dm_rv = 1; e_dm_rdata = m_data; end
          else begin e_if_rv = 1; e_if_rdata = m_data; end
          busy = 0;
        end
      end
    end
  end

  // Compare process: every cycle, away from the clock edge.
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      chk("reset_ctrl", 32'({if_gnt, if_rvalid, dm_gnt, dm_rvalid, mem_req, mem_we,
                             err, stall_if, stall_mem}), 32'd0);
      chk("reset_data", if_rdata | dm_rdata | mem_addr | mem_wdata, 32'd0);
    end else begin
      chk("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
      chk("dm_gnt", 32'(dm_gnt), 32'(e_dm_gnt));
      chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
      chk("dm_rvalid", 32'(dm_rvalid), 32'(e_dm_rv));
      chk("err", 32'(err), 32'(e_err));
      chk("mem_req", 32'(mem_req), 32'(busy));
      if (e_if_rv) chk("if_rdata", if_rdata, e_if_rdata);
      if (e_dm_rv) chk("dm_rdata", dm_rdata, e_dm_rdata);
      if (busy) begin
        chk("mem_addr", mem_addr, cur.addr);
        chk("mem_we", 32'(mem_we), 32'(cur.we));
        chk("mem_wdata", mem_wdata, cur.wdata);
      end
      chk("stall_if", 32'(stall_if), 32'(if_req & ~e_if_rv));
      chk("stall_mem", 32'(stall_mem), 32'(dm_req & ~e_dm_rv));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] raddr();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  logic [31:0] g_addr, g_wdata;
  logic        g_we;

  task automatic dm_xfer(input logic we, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output bit ok);
    ok = 0;
    rd = '0;
    dm_req = 1; dm_we = we; dm_addr = a; dm_wdata = wd;
    for (int k = 0; k < 40 && !ok; k++) begin
      tick();
      if (dm_gnt) begin
        dm_req = 0;
        g_we = mem_we; g_addr = mem_addr; g_wdata = mem_wdata;
      end
      if (dm_rvalid) begin
        rd = dm_rdata;
        ok = 1;
      end
    end
    dm_req = 0;
  endtask

  initial begin
    int c0, gc, rc, mc, ec, n, cnt_g, cnt_r, cnt_w, cnt_ifr;
    bit got_g, got_r, ok;
    logic [31:0] rd, saved;
    logic [9:0] gpat;
    logic erv;
    logic [31:0] erd;

    for (int i = 0; i < 256; i++) begin
      phys[i] = $urandom;
      img[i] = phys[i];
    end
    #1 rst_n = 0;
    repeat (3) tick();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_stall_if", 32'(stall_if), 32'd0);
    rst_n = 1;
    tick();

    // 1: IF fetch, memory answers in the 3rd ACCESS cycle
    phys[4] = 32'h0010_0093; img[4] = 32'h0010_0093;
    mem_mode = 1; fixed_delay = 3; noise_pct = 0;
    tick();
    c0 = cyc; gc = 0; rc = 0; got_g = 0; got_r = 0; rd = '0;
    if_addr = 32'h10; if_req = 1;
    for (int k = 0; k < 20 && !got_r; k++) begin
      tick();
      if (if_gnt) begin got_g = 1; gc = cyc; end
      if (if_rvalid) begin got_r = 1; rc = cyc; rd = if_rdata; if_req = 0; end
    end
    if_req = 0;
    chk("t1_gnt_seen", 32'(got_g), 32'd1);
    chk("t1_rv_seen", 32'(got_r), 32'd1);
    chk("t1_gnt_lat", 32'(gc - c0), 32'd1);
    chk("t1_rv_lat", 32'(rc - c0), 32'd4);
    chk("t1_rdata", rd, 32'h0010_0093);

    // 2: store then load of 0x100
    fixed_delay = 2;
    tick();
    dm_xfer(1'b1, 32'h100, 32'hDEAD_BEEF, rd, ok);
    chk("t2_store_done", 32'(ok), 32'd1);
    chk("t2_mem_we", 32'(g_we), 32'd1);
    chk("t2_mem_addr", g_addr, 32'h100);
    chk("t2_mem_wdata", g_wdata, 32'hDEAD_BEEF);
    chk("t2_store_rdata", rd, 32'd0);
    dm_xfer(1'b0, 32'h100, 32'h0, rd, ok);
    chk("t2_load_done", 32'(ok), 32'd1);
    chk("t2_load_rdata", rd, 32'hDEAD_BEEF);

    // 3: both requesters held high; IF forced in after 4 MEM grants
    tick();
    if_addr = 32'h20; dm_we = 0; dm_addr = 32'h40; dm_wdata = 0;
    if_req = 1; dm_req = 1;
    n = 0; gpat = '0;
    for (int k = 0; k < 200 && n < 10; k++) begin
      tick();
      if (if_gnt || dm_gnt) begin
        gpat = {gpat[8:0], if_gnt};
        n++;
      end
    end
    if_req = 0; dm_req = 0;
    chk("t3_count", 32'(n), 32'd10);
    chk("t3_order", 32'(gpat), 32'(10'b0000100001));
    repeat (6) tick();

    // 4: MEM load with no mem_ready -> abort after 16 ACCESS cycles
    mem_mode = 2; noise_pct = 100;
    tick();
    dm_req = 1; dm_we = 0; dm_addr = 32'h80;
    mc = 0; ec = 0; erv = 0; erd = 32'hFFFF_FFFF; got_r = 0;
    for (int k = 0; k < 40 && !got_r; k++) begin
      tick();
      if (dm_gnt) begin dm_req = 0; mc = cyc; end
      if (err) begin got_r = 1; ec = cyc; erv = dm_rvalid; erd = dm_rdata; end
    end
    dm_req = 0;
    chk("t4_err_seen", 32'(got_r), 32'd1);
    chk("t4_err_lat", 32'(ec - mc), 32'd16);
    chk("t4_rv_with_err", 32'(erv), 32'd1);
    chk("t4_rdata_zero", erd, 32'd0);
    cnt_r = 0;
    repeat (6) begin
      tick();
      if (dm_rvalid || if_rvalid) cnt_r++;
    end
    chk("t4_late_ready_rv", 32'(cnt_r), 32'd0);
    noise_pct = 0;

    // 5: reset in the 2nd ACCESS cycle of an IF fetch
    mem_mode = 1; fixed_delay = 5;
    tick();
    if_addr = 32'h30; if_req = 1; got_g = 0;
    for (int k = 0; k < 5 && !got_g; k++) begin
      tick();
      if (if_gnt) got_g = 1;
    end
    chk("t5_gnt_seen", 32'(got_g), 32'd1);
    tick();
    #3 rst_n = 0;
    #1;
    chk("t5_mem_req", 32'(mem_req), 32'd0);
    chk("t5_if_gnt", 32'(if_gnt), 32'd0);
    chk("t5_if_rvalid", 32'(if_rvalid), 32'd0);
    chk("t5_stall_if", 32'(stall_if), 32'd0);
    tick();
    tick();
    rst_n = 1; if_req = 0;
    dm_req = 1; dm_we = 0; dm_addr = 32'h44;
    c0 = cyc; gc = 0; got_g = 0; got_r = 0;
    for (int k = 0; k < 20 && !got_r; k++) begin
      tick();
      if (dm_gnt) begin got_g = 1; gc = cyc; dm_req = 0; end
      if (dm_rvalid) got_r = 1;
    end
    dm_req = 0;
    chk("t5_dm_gnt_lat", 32'(gc - c0), 32'd1);
    chk("t5_dm_rv_seen", 32'(got_r), 32'd1);

    // 6: dm_req pulsed for one cycle while IF is in ACCESS
    fixed_delay = 4;
    tick();
    saved = phys[8'h18];
    if_addr = 32'h50; if_req = 1; got_g = 0;
    for (int k = 0; k < 5 && !got_g; k++) begin
      tick();
      if (if_gnt) got_g = 1;
    end
    if_req = 0;
    dm_req = 1; dm_we = 1; dm_addr = 32'h60; dm_wdata = 32'hA5A5_5A5A;
    tick();
    dm_req = 0;
    cnt_g = 0; cnt_r = 0; cnt_w = 0; cnt_ifr = 0;
    repeat (8) begin
      if (dm_gnt) cnt_g++;
      if (dm_rvalid) cnt_r++;
      if (mem_req && mem_we) cnt_w++;
      if (if_rvalid) cnt_ifr++;
      tick();
    end
    chk("t6_gnt_seen", 32'(got_g), 32'd1);
    chk("t6_no_dm_gnt", 32'(cnt_g), 32'd0);
    chk("t6_no_dm_rv", 32'(cnt_r), 32'd0);
    chk("t6_no_write", 32'(cnt_w), 32'd0);
    chk("t6_mem_unchanged", phys[8'h18], saved);
    chk("t6_if_rv_once", 32'(cnt_ifr), 32'd1);

    // Randomized traffic against the reference model
    mem_mode = 0; noise_pct = 10;
    tick();
    for (int k = 0; k < 3000; k++) begin
      tick();
      if (if_req && if_gnt) begin
        if ($urandom_range(0, 1) == 1) if_addr = raddr();
        else if_req = 0;
      end else if (if_req && $urandom_range(0, 15) == 0) begin
        if_req = 0;
      end else if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1; if_addr = raddr();
      end
      if (dm_req && dm_gnt) begin
        if ($urandom_range(0, 1) == 1) begin
          dm_addr = raddr(); dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
        end else dm_req = 0;
      end else if (dm_req && $urandom_range(0, 15) == 0) begin
        dm_req = 0;
      end else if (!dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1; dm_addr = raddr(); dm_we = 1'($urandom_range(0, 1)); dm_wdata = $urandom;
      end
    end
    if_req = 0; dm_req = 0;
    repeat (30) tick();
    chk("final_idle", 32'(mem_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
